instruction_fetch: RTL and testbench

Consumer side of the program counter: accepts fetch addresses from the PC block over a valid/ready handshake and issues single-outstanding reads to instruction memory/cache over a req/ack handshake. Returned words are buffered with their address in a small FIFO and presented to decode over valid/ready. A synchronous flush, driven on taken branches, discards buffered and in-flight instructions so no wrong-path instruction reaches decode.

---
 rtl/arm_lp_pkg.sv | 25 ++
 rtl/instruction_fetch_fifo.sv | 79 +++++++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arm_lp_pkg.sv
// Shared types for the fetch front end: default widths, fetch FSM states and
// the buffered instruction entry layout.
package arm_lp_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 32;
  localparam int unsigned INSTR_W_DEFAULT = 32;

  // IDLE: nothing outstanding; REQ: outstanding, keep data; DROP: outstanding, discard data
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0]  addr;
    logic [INSTR_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

  // Circular-buffer pointer increment, wrapping at depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// DEPTH-entry circular buffer holding fetched {address, instruction} pairs.
// Clear has priority over push and pop; head outputs read from registered state.
module fetch_fifo
  import arm_lp_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PtrW'(wrap_inc(32'(wr_ptr_q), DEPTH));
      if (pop)  rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), DEPTH));
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; a push during clear is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head is zeroed when empty so stale entries never show after a flush.
  always_comb begin
    head_valid = (count_q != '0);
    head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    count      = count_q;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: accepts PCs, issues single-outstanding imem reads, buffers the
// returned words and presents them to decode. Flush discards buffered and
// in-flight fetches.
module instruction_fetch
  import arm_lp_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned EntW  = ADDR_W + INSTR_W;

  fetch_state_t      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic [CntW-1:0]   fifo_count;
  logic [EntW-1:0]   head_data;
  logic              head_valid;

  // Space is reserved at accept time, so an ack always finds a free slot.
  always_comb begin
    pc_ready = (state_q == IDLE) && (fifo_count < CntW'(DEPTH)) && !flush;
    accept   = pc_valid && pc_ready;
    pop      = head_valid && instr_ready && !flush;
  end

  // FSM next-state, request register and push decision.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = pc;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          push    = !flush;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (flush) begin
          // Request must stay up until ack; its data will be thrown away.
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (flush),
    .push       (push),
    .push_data  ({addr_q, imem_rdata}),
    .pop        (pop),
    .count      (fifo_count),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

  // Outputs decode from registered state only.
  always_comb begin
    imem_req    = req_q;
    imem_addr   = addr_q;
    instr_valid = head_valid;
    instr_pc    = head_data[EntW-1:INSTR_W];
    instr       = head_data[INSTR_W-1:0];
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch with a queue-based reference model and
// a separate monitor that checks every instruction delivered to decode.
module tb_instruction_fetch;
  import arm_lp_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned NCYC  = 4000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  instruction_fetch #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Scoreboard: instructions decode should receive, oldest first.
  fetch_entry_t sb_q[$];

  // Reference model of the memory transaction in flight.
  bit          outstanding = 1'b0;
  bit          discard     = 1'b0;
  logic [31:0] m_addr      = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 64'(imem_req), 64'd0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_instr"}, 64'(instr), 64'd0);
    chk({tag, "_instr_pc"}, 64'(instr_pc), 64'd0);
  endtask

  // Monitor: whenever decode takes the head, it must match the oldest expectation.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset_n && instr_valid && instr_ready && !flush) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got instr_pc %0h expected no instruction", instr_pc);
        end else begin
          e = sb_q.pop_front();
          chk("instr", 64'(instr), 64'(e.instr));
          chk("instr_pc", 64'(instr_pc), 64'(e.addr));
        end
      end
    end
  end

  // Driver and reference model.
  initial begin
    logic [31:0]  next_pc;
    bit           first_ack;
    bit           did_reset;
    bit           exp_ready;
    int unsigned  pv_p, ack_p, rdy_p, fl_p;
    fetch_entry_t e;

    reset_n     = 1'b0;
    pc          = '0;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    next_pc     = 32'h100;
    first_ack   = 1'b1;
    did_reset   = 1'b0;

    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    chk("reset_pc_ready", 64'(pc_ready), 64'd1);
    reset_n = 1'b1;

    for (int c = 0; c < int'(NCYC); c++) begin
      @(negedge clock);
      case (c / 1000)
        0:       begin pv_p = 80;  ack_p = 60;  rdy_p = 70;  fl_p = 0;  end
        1:       begin pv_p = 90;  ack_p = 40;  rdy_p = 10;  fl_p = 3;  end
        2:       begin pv_p = 70;  ack_p = 35;  rdy_p = 60;  fl_p = 15; end
        default: begin pv_p = 100; ack_p = 100; rdy_p = 100; fl_p = 0;  end
      endcase

      // Reset while a request is outstanding and the buffer is non-empty.
      if (!did_reset && c >= 1500 && ((outstanding && sb_q.size() >= 1) || c == 1999)) begin
        did_reset = 1'b1;
        reset_n   = 1'b0;
        pc_valid  = 1'b0;
        flush     = 1'b0;
        imem_ack  = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb_q.delete();
        outstanding = 1'b0;
        discard     = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        continue;
      end

      pc_valid    = ($urandom_range(99) < pv_p);
      pc          = next_pc;
      flush       = ($urandom_range(99) < fl_p);
      instr_ready = ($urandom_range(99) < rdy_p);
      imem_ack    = outstanding ? ($urandom_range(99) < ack_p) : ($urandom_range(19) == 0);
      imem_rdata  = $urandom();
      if (outstanding && imem_ack && first_ack) begin
        imem_rdata = 32'hF800_0000;
        first_ack  = 1'b0;
      end
      #1;

      exp_ready = !outstanding && (sb_q.size() < DEPTH) && !flush;
      chk("pc_ready", 64'(pc_ready), 64'(exp_ready));
      chk("instr_valid", 64'(instr_valid), 64'(sb_q.size() != 0));
      chk("imem_req", 64'(imem_req), 64'(outstanding));
      if (outstanding) chk("imem_addr", 64'(imem_addr), 64'(m_addr));

      // Apply this cycle's events to the model.
      if (flush) sb_q.delete();
      if (outstanding && imem_ack) begin
        if (!discard && !flush) begin
          e.addr  = m_addr;
          e.instr = imem_rdata;
          sb_q.push_back(e);
        end
        outstanding = 1'b0;
        discard     = 1'b0;
      end else if (outstanding && flush) begin
        discard = 1'b1;
      end
      if (pc_valid && exp_ready) begin
        outstanding = 1'b1;
        discard     = 1'b0;
        m_addr      = pc;
        next_pc     = ($urandom_range(9) == 0) ? ($urandom() & 32'hFFFF_FFFC) : next_pc + 32'd8;
      end
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
